button_debounce: RTL and testbench
==================================

Name: button_debounce

Overview:
- Conditions the five raw push-button inputs before they reach the memory-mapped button read port at 0xFFFF_F078.
- Per channel: 2-flop synchroniser, then a saturating stability counter, then a debounced level and a one-cycle press pulse.
- Output `button_db[4:0]` drives the read port's `button` input directly, so the CPU only ever sees clean, held levels.

Parameters:
- CNT_MAX, 200000, consecutive cycles a synchronised input must differ from the debounced level before the level flips (about 8 ms at 25 MHz); legal range 2 to 2^CNT_W-1.
- CNT_W, 18, counter width; must satisfy 2^CNT_W > CNT_MAX.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- btn_raw  in  5  raw board buttons S4..S0, asynchronous to clk, 1 = pressed.
- button_db  out  5  debounced level per channel, registered; feeds the button read port.
- btn_press  out  5  one-cycle pulse per channel on debounced 0->1.
- btn_release  out  5  one-cycle pulse per channel on debounced 1->0.

Behaviour:
- Reset (`rst` low, asynchronous): sync stages, counters, `button_db`, `btn_press` and `btn_release` all go to 0 immediately and hold while `rst` is low.
- Reset release: the first active edge is the first rising `clk` with `rst` high.
- Synchroniser, per channel i:
  - `s1[i]` <= `btn_raw[i]`
  - `s2[i]` <= `s1[i]`
  - `s2` is the only signal the counter logic sees.
- Counter, per channel, one clocked process:
  - if `s2[i]` == `button_db[i]`: `cnt[i]` <= 0
  - else if `cnt[i]` == CNT_MAX-1: `button_db[i]` <= `s2[i]`; `cnt[i]` <= 0
  - else: `cnt[i]` <= `cnt[i]`+1
- Latency:
  - Raw change captured into `s1` at edge k and held stable: `button_db` changes after edge k+1+CNT_MAX.
  - That is 2 sync + (CNT_MAX-1) count cycles.
- Glitch rejection: any `s2` sample equal to `button_db` clears the counter. A bounce shorter than CNT_MAX consecutive cycles never changes `button_db`; counting restarts from 0 on the next mismatch.
- Pulses (registered, same edge as the level flip):
  - `btn_press[i]` <= 1 exactly on the edge where `button_db[i]` goes 0->1; 0 on every other edge.
  - `btn_release[i]` <= 1 exactly on the edge where `button_db[i]` goes 1->0; 0 on every other edge.
  - Never both high on the same channel; each pulse lasts exactly one cycle.
- Channel independence:
  - Five identical, independent channels; simultaneous presses are debounced independently.
  - Several `button_db` bits may be 1 at once. Rejecting non-one-hot codes is the read port's job, not this block's.
- Counter width: the counter never exceeds CNT_MAX-1, so there is no wrap-around.
- Reset mid-count: counter and level cleared. After release, a still-held button needs a full 2+CNT_MAX cycles to reassert.
- Pure sequential datapath:
  - No combinational path from `btn_raw` to any output.
  - All outputs are flop outputs.

Test Plan (CNT_MAX=4, CNT_W=3, raw changes applied mid-cycle):
- Reset: hold `rst`=0 with `btn_raw`=5'b11111 for 10 cycles -> `button_db`, `btn_press` and `btn_release` all 0; assert `rst` low asynchronously mid-cycle during a press -> outputs 0 before the next clk edge.
- Clean press: `btn_raw`=5'b00001 captured at edge k, held -> `button_db`=5'b00001 and `btn_press`=5'b00001 after edge k+5; `btn_press` 0 again after edge k+6; read port then returns 0x11111111.
- Bounce: on channel 2, toggle 1,0,1,0 every 3 cycles, then hold 1 -> no change while toggling; `button_db[2]` rises exactly 5 edges after the final stable 1 is captured; exactly one `btn_press[2]` pulse.
- Release: from `button_db`=5'b10000, drop `btn_raw[4]` at edge k -> `button_db[4]`=0 and `btn_release`=5'b10000 for one cycle after edge k+5; `btn_press` stays 0.
- Simultaneous: `btn_raw`=5'b00110 pressed together -> `button_db`=5'b00110 after the same edge, both press pulses in the same cycle; release S1 only -> `button_db`=5'b00100 after 5 edges.
- Reset mid-count: press S3, pulse `rst` low 2 cycles after capture, release `rst` with S3 still held -> `button_db[3]` rises 5 edges after the first post-reset capture edge, with one press pulse.

Source files
------------

// File: rtl/button_debounce.sv
// Five-channel push-button conditioner: 2-flop synchroniser, saturating
// stability counter, debounced level and one-cycle press/release pulses.
module button_debounce #(
  parameter int unsigned CNT_MAX = 200000,
  parameter int unsigned CNT_W   = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] btn_raw,
  output logic [4:0] button_db,
  output logic [4:0] btn_press,
  output logic [4:0] btn_release
);

  localparam int unsigned N_BTN = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic [N_BTN-1:0]            s1_q, s1_d;
  logic [N_BTN-1:0]            s2_q, s2_d;
  logic [N_BTN-1:0]            db_q, db_d;
  logic [N_BTN-1:0]            press_q, press_d;
  logic [N_BTN-1:0]            release_q, release_d;
  logic [N_BTN-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // Synchroniser shift plus per-channel stability counting; only s2 feeds the counters.
  always_comb begin
    s1_d      = btn_raw;
    s2_d      = s1_q;
    db_d      = db_q;
    cnt_d     = cnt_q;
    press_d   = '0;
    release_d = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      if (s2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        db_d[i]      = s2_q[i];
        cnt_d[i]     = '0;
        press_d[i]   = s2_q[i];
        release_d[i] = ~s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      db_q      <= '0;
      cnt_q     <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      db_q      <= db_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign button_db   = db_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce: directed scenarios plus randomized
// stimulus compared every cycle against a streak-counting reference model.
module tb_button_debounce;

  localparam int unsigned CNT_MAX = 4;
  localparam int unsigned CNT_W   = 3;

  logic       clk;
  logic       rst;
  logic [4:0] btn_raw;
  logic [4:0] button_db;
  logic [4:0] btn_press;
  logic [4:0] btn_release;

  int errors = 0;
  int checks = 0;

  button_debounce #(.CNT_MAX(CNT_MAX), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .button_db  (button_db),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: raw value is visible to the debouncer two edges after capture;
  // the level flips on the CNT_MAX-th consecutive sample that disagrees with it.
  logic [4:0] m_pipe0, m_pipe1, m_db, m_press, m_rel;
  int         streak [5];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pipe0 = '0; m_pipe1 = '0; m_db = '0; m_press = '0; m_rel = '0;
      for (int i = 0; i < 5; i++) streak[i] = 0;
    end else begin
      m_press = '0;
      m_rel   = '0;
      for (int i = 0; i < 5; i++) begin
        if (m_pipe1[i] != m_db[i]) begin
          streak[i] = streak[i] + 1;
          if (streak[i] == int'(CNT_MAX)) begin
            m_db[i]    = m_pipe1[i];
            m_press[i] = m_pipe1[i];
            m_rel[i]   = ~m_pipe1[i];
            streak[i]  = 0;
          end
        end else begin
          streak[i] = 0;
        end
      end
      m_pipe1 = m_pipe0;
      m_pipe0 = btn_raw;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    btn_raw = 5'b11111;
    repeat (10) tick();
    checks++;
    if ({button_db, btn_press, btn_release} !== 15'd0) begin
      errors++;
      $display("FAIL reset_hold outputs got %b/%b/%b want 0/0/0", button_db, btn_press, btn_release);
    end
    rst = 1'b1;
    repeat (7) tick();
    checks++;
    if (button_db !== 5'b11111) begin
      errors++;
      $display("FAIL reset_prepress db got %b want 11111", button_db);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({button_db, btn_press, btn_release} !== 15'd0) begin
      errors++;
      $display("FAIL reset_async outputs got %b/%b/%b want 0/0/0", button_db, btn_press, btn_release);
    end
    tick();
    btn_raw = '0;
    tick();
    rst = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_clean_press();
    btn_raw = 5'b00001;
    for (int c = 1; c <= 8; c++) begin
      tick();
      checks++;
      if ({button_db, btn_press, btn_release} !== {m_db, m_press, m_rel}) begin
        errors++;
        $display("FAIL clean_press model c=%0d got %b/%b/%b want %b/%b/%b", c,
                 button_db, btn_press, btn_release, m_db, m_press, m_rel);
      end
      if (c == 5) begin
        checks++;
        if (button_db !== 5'b00000) begin
          errors++;
          $display("FAIL clean_press early db got %b want 00000", button_db);
        end
      end
      if (c == 6) begin
        checks++;
        if (button_db !== 5'b00001 || btn_press !== 5'b00001) begin
          errors++;
          $display("FAIL clean_press edge db/press got %b/%b want 00001/00001", button_db, btn_press);
        end
      end
      if (c == 7) begin
        checks++;
        if (btn_press !== 5'b00000) begin
          errors++;
          $display("FAIL clean_press pulse_width press got %b want 00000", btn_press);
        end
      end
    end
    btn_raw = '0;
    repeat (8) tick();
  endtask

  task automatic test_bounce();
    int npress = 0;
    logic [3:0] seq = 4'b1010;
    for (int s = 0; s < 4; s++) begin
      btn_raw[2] = seq[3-s];
      for (int c = 0; c < 3; c++) begin
        tick();
        if (btn_press[2]) npress++;
        checks++;
        if (button_db !== m_db || btn_press !== m_press || button_db[2] !== 1'b0) begin
          errors++;
          $display("FAIL bounce toggling db/press got %b/%b want %b/%b", button_db, btn_press, m_db, m_press);
        end
      end
    end
    btn_raw[2] = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (btn_press[2]) npress++;
      checks++;
      if ({button_db, btn_press, btn_release} !== {m_db, m_press, m_rel}) begin
        errors++;
        $display("FAIL bounce model c=%0d got %b/%b/%b want %b/%b/%b", c,
                 button_db, btn_press, btn_release, m_db, m_press, m_rel);
      end
      if (c == 5 || c == 6) begin
        checks++;
        if (button_db[2] !== (c == 6)) begin
          errors++;
          $display("FAIL bounce rise c=%0d db2 got %b want %b", c, button_db[2], (c == 6));
        end
      end
    end
    checks++;
    if (npress != 1) begin
      errors++;
      $display("FAIL bounce press_count got %0d want 1", npress);
    end
    btn_raw = '0;
    repeat (8) tick();
  endtask

  task automatic test_release();
    btn_raw = 5'b10000;
    repeat (8) tick();
    checks++;
    if (button_db !== 5'b10000) begin
      errors++;
      $display("FAIL release_setup db got %b want 10000", button_db);
    end
    btn_raw = 5'b00000;
    for (int c = 1; c <= 8; c++) begin
      tick();
      checks++;
      if ({button_db, btn_press, btn_release} !== {m_db, m_press, m_rel} || btn_press !== 5'b0) begin
        errors++;
        $display("FAIL release model c=%0d got %b/%b/%b want %b/00000/%b", c,
                 button_db, btn_press, btn_release, m_db, m_rel);
      end
      if (c == 6) begin
        checks++;
        if (button_db[4] !== 1'b0 || btn_release !== 5'b10000) begin
          errors++;
          $display("FAIL release edge db/rel got %b/%b want 00000/10000", button_db, btn_release);
        end
      end
      if (c == 7) begin
        checks++;
        if (btn_release !== 5'b00000) begin
          errors++;
          $display("FAIL release pulse_width rel got %b want 00000", btn_release);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    btn_raw = 5'b00110;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 6) begin
        checks++;
        if (button_db !== 5'b00110 || btn_press !== 5'b00110) begin
          errors++;
          $display("FAIL simul_press db/press got %b/%b want 00110/00110", button_db, btn_press);
        end
      end
    end
    btn_raw = 5'b00100;
    for (int c = 1; c <= 8; c++) begin
      tick();
      checks++;
      if ({button_db, btn_press, btn_release} !== {m_db, m_press, m_rel}) begin
        errors++;
        $display("FAIL simul model c=%0d got %b/%b/%b want %b/%b/%b", c,
                 button_db, btn_press, btn_release, m_db, m_press, m_rel);
      end
      if (c == 6) begin
        checks++;
        if (button_db !== 5'b00100 || btn_release !== 5'b00010) begin
          errors++;
          $display("FAIL simul_release db/rel got %b/%b want 00100/00010", button_db, btn_release);
        end
      end
    end
    btn_raw = '0;
    repeat (8) tick();
  endtask

  task automatic test_reset_mid_count();
    int npress = 0;
    btn_raw = 5'b01000;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({button_db, btn_press, btn_release} !== 15'd0) begin
      errors++;
      $display("FAIL reset_mid in_reset got %b/%b/%b want 0/0/0", button_db, btn_press, btn_release);
    end
    rst = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (btn_press[3]) npress++;
      checks++;
      if ({button_db, btn_press, btn_release} !== {m_db, m_press, m_rel}) begin
        errors++;
        $display("FAIL reset_mid model c=%0d got %b/%b/%b want %b/%b/%b", c,
                 button_db, btn_press, btn_release, m_db, m_press, m_rel);
      end
      if (c == 5 || c == 6) begin
        checks++;
        if (button_db[3] !== (c == 6)) begin
          errors++;
          $display("FAIL reset_mid rise c=%0d db3 got %b want %b", c, button_db[3], (c == 6));
        end
      end
    end
    checks++;
    if (npress != 1) begin
      errors++;
      $display("FAIL reset_mid press_count got %0d want 1", npress);
    end
    btn_raw = '0;
    repeat (8) tick();
  endtask

  task automatic test_random();
    int hold = 0;
    for (int c = 0; c < 600; c++) begin
      if (hold == 0) begin
        btn_raw = 5'($urandom);
        hold = $urandom_range(1, 2 * CNT_MAX);
      end
      hold--;
      tick();
      checks++;
      if ({button_db, btn_press, btn_release} !== {m_db, m_press, m_rel}) begin
        errors++;
        $display("FAIL random model c=%0d raw=%b got %b/%b/%b want %b/%b/%b", c, btn_raw,
                 button_db, btn_press, btn_release, m_db, m_press, m_rel);
      end
      checks++;
      if ((btn_press & btn_release) !== 5'b0) begin
        errors++;
        $display("FAIL random both_pulses got %b want 00000", btn_press & btn_release);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    btn_raw = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_simultaneous();
    test_reset_mid_count();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
